// File: rtl/fbuf_write_controller.sv
// ----------------------------------------------------------------------------
// fbuf_write_controller
//
// Owns the framebuffer BRAM write port. Upstream pixel writes pass through
// with one register stage and are bounds-checked against the stored frame
// size. A low level on pixel_fbuf_rst_req_n starts a full-frame clear sweep
// that writes CLEAR_COLOR to every location. Upstream writes that arrive
// during the sweep, or while the request is still held low after the sweep,
// are dropped and counted.
//
// Ports:
//   clk                   system clock
//   rst_n                 synchronous active-low reset
//   pixel_fbuf_address    upstream write address
//   pixel_fbuf_color      upstream write data (RGB332)
//   pixel_fbuf_wr_en      upstream write strobe
//   pixel_fbuf_rst_req_n  active-low clear request (level)
//   bram_addr             registered BRAM write address
//   bram_din              registered BRAM write data
//   bram_we               registered BRAM write enable
//   clear_busy            high while outputs come from CLEAR or HOLD
//   frame_done            one-cycle pulse with the pass-through write to the
//                         last address of the frame
//   range_err             sticky out-of-range upstream write flag
//   dropped_count         saturating count of dropped upstream writes
// ----------------------------------------------------------------------------
module fbuf_write_controller #(
  parameter int FRAME_WIDTH     = 640,
  parameter int FRAME_HEIGHT    = 480,
  parameter int SCALING_FACTOR  = 1,
  parameter int FBUF_ADDR_WIDTH = 19,
  parameter int FBUF_DATA_WIDTH = 8,
  parameter int CLEAR_COLOR     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [FBUF_ADDR_WIDTH-1:0] pixel_fbuf_address,
  input  logic [FBUF_DATA_WIDTH-1:0] pixel_fbuf_color,
  input  logic                       pixel_fbuf_wr_en,
  input  logic                       pixel_fbuf_rst_req_n,
  output logic [FBUF_ADDR_WIDTH-1:0] bram_addr,
  output logic [FBUF_DATA_WIDTH-1:0] bram_din,
  output logic                       bram_we,
  output logic                       clear_busy,
  output logic                       frame_done,
  output logic                       range_err,
  output logic [15:0]                dropped_count
);

  localparam longint unsigned DEPTH =
    longint'(FRAME_WIDTH / SCALING_FACTOR) * longint'(FRAME_HEIGHT / SCALING_FACTOR);

  // The stored frame must fit in the address space of the BRAM port.
  generate
    if (DEPTH > (longint'(1) << FBUF_ADDR_WIDTH)) begin : g_depth_check
      $error("fbuf_write_controller: frame depth exceeds 2**FBUF_ADDR_WIDTH");
    end
  endgenerate

  // One extra bit so DEPTH == 2**FBUF_ADDR_WIDTH is still representable.
  localparam logic [FBUF_ADDR_WIDTH:0]   DEPTH_W   = (FBUF_ADDR_WIDTH+1)'(DEPTH);
  localparam logic [FBUF_ADDR_WIDTH-1:0] LAST_ADDR = FBUF_ADDR_WIDTH'(DEPTH - 1);
  localparam logic [FBUF_DATA_WIDTH-1:0] CLR_DATA  = FBUF_DATA_WIDTH'(CLEAR_COLOR);

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t                     state_q;
  logic [FBUF_ADDR_WIDTH-1:0] clr_cnt_q;
  logic [FBUF_ADDR_WIDTH-1:0] bram_addr_q;
  logic [FBUF_DATA_WIDTH-1:0] bram_din_q;
  logic                       bram_we_q;
  logic                       clear_busy_q;
  logic                       frame_done_q;
  logic                       range_err_q;
  logic [15:0]                dropped_count_q;

  logic in_range;
  logic drop_sat;

  assign in_range = ({1'b0, pixel_fbuf_address} < DEPTH_W);
  assign drop_sat = (dropped_count_q == 16'hFFFF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= ST_PASS;
      clr_cnt_q       <= '0;
      bram_addr_q     <= '0;
      bram_din_q      <= '0;
      bram_we_q       <= 1'b0;
      clear_busy_q    <= 1'b0;
      frame_done_q    <= 1'b0;
      range_err_q     <= 1'b0;
      dropped_count_q <= '0;
    end else begin
      case (state_q)
        ST_PASS: begin
          bram_addr_q  <= pixel_fbuf_address;
          bram_din_q   <= pixel_fbuf_color;
          bram_we_q    <= pixel_fbuf_wr_en && in_range;
          frame_done_q <= pixel_fbuf_wr_en && (pixel_fbuf_address == LAST_ADDR);
          clear_busy_q <= 1'b0;
          if (pixel_fbuf_wr_en && !in_range) begin
            range_err_q <= 1'b1;
          end
          // The write sampled together with the request still goes through;
          // the sweep starts on the following cycle.
          if (!pixel_fbuf_rst_req_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
          end
        end

        ST_CLEAR: begin
          bram_addr_q  <= clr_cnt_q;
          bram_din_q   <= CLR_DATA;
          bram_we_q    <= 1'b1;
          frame_done_q <= 1'b0;
          clear_busy_q <= 1'b1;
          if (pixel_fbuf_wr_en && !drop_sat) begin
            dropped_count_q <= dropped_count_q + 16'd1;
          end
          // The sweep always runs to the last address; the request level is
          // only consulted once the final location has been issued.
          if (clr_cnt_q == LAST_ADDR) begin
            state_q <= pixel_fbuf_rst_req_n ? ST_PASS : ST_HOLD;
          end else begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end

        ST_HOLD: begin
          bram_we_q    <= 1'b0;
          frame_done_q <= 1'b0;
          clear_busy_q <= 1'b1;
          if (pixel_fbuf_wr_en && !drop_sat) begin
            dropped_count_q <= dropped_count_q + 16'd1;
          end
          if (pixel_fbuf_rst_req_n) begin
            state_q <= ST_PASS;
          end
        end

        default: begin
          state_q      <= ST_PASS;
          bram_we_q    <= 1'b0;
          frame_done_q <= 1'b0;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bram_addr     = bram_addr_q;
  assign bram_din      = bram_din_q;
  assign bram_we       = bram_we_q;
  assign clear_busy    = clear_busy_q;
  assign frame_done    = frame_done_q;
  assign range_err     = range_err_q;
  assign dropped_count = dropped_count_q;

endmodule

// File: tb/tb_fbuf_write_controller.sv
module tb_fbuf_write_controller;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int SDEPTH = 4800;     // SCALING_FACTOR = 8: 80 x 60
  localparam int DDEPTH = 307200;   // default 640 x 480

  logic clk;
  logic rst_n;

  // Scaled instance (DEPTH = 4800)
  logic [AW-1:0] s_addr_i;
  logic [DW-1:0] s_color_i;
  logic          s_wr_i;
  logic          s_req_n_i;
  logic [AW-1:0] s_bram_addr;
  logic [DW-1:0] s_bram_din;
  logic          s_bram_we;
  logic          s_busy;
  logic          s_fd;
  logic          s_rerr;
  logic [15:0]   s_cnt;

  // Default instance (DEPTH = 307200)
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_color_i;
  logic          d_wr_i;
  logic          d_req_n_i;
  logic [AW-1:0] d_bram_addr;
  logic [DW-1:0] d_bram_din;
  logic          d_bram_we;
  logic          d_busy;
  logic          d_fd;
  logic          d_rerr;
  logic [15:0]   d_cnt;

  int total;
  int bad;

  fbuf_write_controller #(
    .FRAME_WIDTH(640), .FRAME_HEIGHT(480), .SCALING_FACTOR(8),
    .FBUF_ADDR_WIDTH(AW), .FBUF_DATA_WIDTH(DW), .CLEAR_COLOR(0)
  ) u_scaled (
    .clk(clk), .rst_n(rst_n),
    .pixel_fbuf_address(s_addr_i), .pixel_fbuf_color(s_color_i),
    .pixel_fbuf_wr_en(s_wr_i), .pixel_fbuf_rst_req_n(s_req_n_i),
    .bram_addr(s_bram_addr), .bram_din(s_bram_din), .bram_we(s_bram_we),
    .clear_busy(s_busy), .frame_done(s_fd), .range_err(s_rerr),
    .dropped_count(s_cnt)
  );

  fbuf_write_controller u_default (
    .clk(clk), .rst_n(rst_n),
    .pixel_fbuf_address(d_addr_i), .pixel_fbuf_color(d_color_i),
    .pixel_fbuf_wr_en(d_wr_i), .pixel_fbuf_rst_req_n(d_req_n_i),
    .bram_addr(d_bram_addr), .bram_din(d_bram_din), .bram_we(d_bram_we),
    .clear_busy(d_busy), .frame_done(d_fd), .range_err(d_rerr),
    .dropped_count(d_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    s_wr_i    = 1'b0; s_req_n_i = 1'b1; s_addr_i = '0; s_color_i = '0;
    d_wr_i    = 1'b0; d_req_n_i = 1'b1; d_addr_i = '0; d_color_i = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    s_wr_i    = 1'b1; s_req_n_i = 1'b0; s_addr_i = 19'd77; s_color_i = 8'hFF;
    d_wr_i    = 1'b1; d_req_n_i = 1'b0; d_addr_i = 19'd77; d_color_i = 8'hFF;
    tick();
    total++;
    if ({s_bram_addr, s_bram_din, s_bram_we, s_busy, s_fd, s_rerr, s_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_scaled: addr=%0d din=%h we=%b busy=%b fd=%b rerr=%b cnt=%0d, required all 0",
               s_bram_addr, s_bram_din, s_bram_we, s_busy, s_fd, s_rerr, s_cnt);
    end
    total++;
    if ({d_bram_addr, d_bram_din, d_bram_we, d_busy, d_fd, d_rerr, d_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_default: addr=%0d din=%h we=%b busy=%b fd=%b rerr=%b cnt=%0d, required all 0",
               d_bram_addr, d_bram_din, d_bram_we, d_busy, d_fd, d_rerr, d_cnt);
    end
    s_wr_i = 1'b0; s_req_n_i = 1'b1;
    d_wr_i = 1'b0; d_req_n_i = 1'b1;
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    apply_reset();
    s_wr_i = 1'b1; s_addr_i = 19'd5; s_color_i = 8'hE0;
    tick();
    total++;
    if ({s_bram_addr, s_bram_din, s_bram_we} !== {19'd5, 8'hE0, 1'b1}) begin
      bad++;
      $display("FAIL pass_write: addr=%0d din=%h we=%b, required addr=5 din=e0 we=1",
               s_bram_addr, s_bram_din, s_bram_we);
    end
    total++;
    if ({s_rerr, s_fd, s_busy} !== 3'b000) begin
      bad++;
      $display("FAIL pass_flags: rerr=%b fd=%b busy=%b, required 000", s_rerr, s_fd, s_busy);
    end
    // Address and data follow the input every cycle even without a strobe.
    s_wr_i = 1'b0; s_addr_i = 19'd6; s_color_i = 8'h1C;
    tick();
    total++;
    if ({s_bram_addr, s_bram_din, s_bram_we} !== {19'd6, 8'h1C, 1'b0}) begin
      bad++;
      $display("FAIL pass_idle: addr=%0d din=%h we=%b, required addr=6 din=1c we=0",
               s_bram_addr, s_bram_din, s_bram_we);
    end
    // Last location of the scaled frame.
    s_wr_i = 1'b1; s_addr_i = 19'd4799; s_color_i = 8'h03;
    tick();
    total++;
    if ({s_bram_we, s_fd, s_rerr} !== 3'b110) begin
      bad++;
      $display("FAIL pass_last_scaled: we=%b fd=%b rerr=%b, required we=1 fd=1 rerr=0",
               s_bram_we, s_fd, s_rerr);
    end
    s_addr_i = 19'd4798;
    tick();
    total++;
    if ({s_bram_we, s_fd} !== 2'b10) begin
      bad++;
      $display("FAIL pass_fd_clear: we=%b fd=%b, required we=1 fd=0", s_bram_we, s_fd);
    end
    s_wr_i = 1'b0;
  endtask

  task automatic test_bounds();
    apply_reset();
    d_wr_i = 1'b1; d_addr_i = 19'd307200; d_color_i = 8'hAA;
    tick();
    total++;
    if ({d_bram_we, d_rerr, d_fd} !== 3'b010) begin
      bad++;
      $display("FAIL bounds_oob: we=%b rerr=%b fd=%b, required we=0 rerr=1 fd=0",
               d_bram_we, d_rerr, d_fd);
    end
    d_addr_i = 19'd307199; d_color_i = 8'h55;
    tick();
    total++;
    if ({d_bram_we, d_fd, d_rerr, d_bram_addr} !== {1'b1, 1'b1, 1'b1, 19'd307199}) begin
      bad++;
      $display("FAIL bounds_last: we=%b fd=%b rerr=%b addr=%0d, required we=1 fd=1 rerr=1 addr=307199",
               d_bram_we, d_fd, d_rerr, d_bram_addr);
    end
    d_wr_i = 1'b0; d_addr_i = 19'd307199;
    tick();
    total++;
    if ({d_bram_we, d_fd, d_rerr} !== 3'b001) begin
      bad++;
      $display("FAIL bounds_sticky: we=%b fd=%b rerr=%b, required we=0 fd=0 rerr=1",
               d_bram_we, d_fd, d_rerr);
    end
    // An out-of-range address without a strobe is not an error.
    apply_reset();
    d_wr_i = 1'b0; d_addr_i = 19'd400000;
    tick();
    total++;
    if (d_rerr !== 1'b0) begin
      bad++;
      $display("FAIL bounds_no_strobe: rerr=%b, required 0", d_rerr);
    end
  endtask

  task automatic test_clear_sweep();
    int errs;
    int first_bad;
    apply_reset();
    s_wr_i = 1'b0; s_req_n_i = 1'b0;
    tick();
    total++;
    if (s_busy !== 1'b0) begin
      bad++;
      $display("FAIL sweep_req_cycle: busy=%b, required 0", s_busy);
    end
    s_req_n_i = 1'b1;
    errs = 0; first_bad = -1;
    for (int i = 0; i < SDEPTH; i++) begin
      tick();
      if (s_bram_addr !== AW'(i) || s_bram_din !== 8'h00 || s_bram_we !== 1'b1 ||
          s_busy !== 1'b1 || s_fd !== 1'b0) begin
        errs++;
        if (first_bad < 0) first_bad = i;
      end
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL sweep_writes: %0d bad cycles, first at index %0d (addr=%0d), required addr=index din=0 we=1 busy=1 fd=0",
               errs, first_bad, s_bram_addr);
    end
    tick();
    total++;
    if ({s_busy, s_bram_we, s_fd} !== 3'b000) begin
      bad++;
      $display("FAIL sweep_end: busy=%b we=%b fd=%b, required 000", s_busy, s_bram_we, s_fd);
    end
    s_wr_i = 1'b1; s_addr_i = 19'd9; s_color_i = 8'h42;
    tick();
    total++;
    if ({s_bram_we, s_bram_addr, s_bram_din, s_cnt} !== {1'b1, 19'd9, 8'h42, 16'd0}) begin
      bad++;
      $display("FAIL sweep_after_pass: we=%b addr=%0d din=%h cnt=%0d, required we=1 addr=9 din=42 cnt=0",
               s_bram_we, s_bram_addr, s_bram_din, s_cnt);
    end
    s_wr_i = 1'b0;
  endtask

  task automatic test_drop_hold();
    apply_reset();
    s_wr_i = 1'b1; s_addr_i = 19'd3; s_color_i = 8'h77; s_req_n_i = 1'b0;
    for (int i = 1; i <= 6000; i++) begin
      tick();
      if (i == 1) begin
        total++;
        if ({s_bram_we, s_bram_addr, s_busy} !== {1'b1, 19'd3, 1'b0}) begin
          bad++;
          $display("FAIL drop_pass_wins: we=%b addr=%0d busy=%b, required we=1 addr=3 busy=0",
                   s_bram_we, s_bram_addr, s_busy);
        end
      end
      if (i == 4801) begin
        total++;
        if ({s_bram_we, s_bram_addr, s_busy} !== {1'b1, 19'd4799, 1'b1}) begin
          bad++;
          $display("FAIL drop_last_clear: we=%b addr=%0d busy=%b, required we=1 addr=4799 busy=1",
                   s_bram_we, s_bram_addr, s_busy);
        end
      end
      if (i == 5000) begin
        total++;
        if ({s_bram_we, s_busy} !== 2'b01) begin
          bad++;
          $display("FAIL drop_hold: we=%b busy=%b, required we=0 busy=1", s_bram_we, s_busy);
        end
      end
    end
    s_req_n_i = 1'b1;
    tick();
    // Release seen in HOLD: still a HOLD output cycle, write dropped.
    total++;
    if ({s_bram_we, s_busy, s_cnt} !== {1'b0, 1'b1, 16'd6000}) begin
      bad++;
      $display("FAIL drop_release: we=%b busy=%b cnt=%0d, required we=0 busy=1 cnt=6000",
               s_bram_we, s_busy, s_cnt);
    end
    tick();
    total++;
    if ({s_bram_we, s_busy, s_bram_addr, s_cnt} !== {1'b1, 1'b0, 19'd3, 16'd6000}) begin
      bad++;
      $display("FAIL drop_pass_after: we=%b busy=%b addr=%0d cnt=%0d, required we=1 busy=0 addr=3 cnt=6000",
               s_bram_we, s_busy, s_bram_addr, s_cnt);
    end
    s_wr_i = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    int budget;
    apply_reset();
    s_wr_i = 1'b1; s_addr_i = 19'd100; s_req_n_i = 1'b0;
    tick();
    s_req_n_i = 1'b1;
    budget = 0;
    while (!(s_busy === 1'b1 && s_bram_addr === 19'd1000) && budget < 2000) begin
      tick();
      budget++;
    end
    total++;
    if (budget >= 2000) begin
      bad++;
      $display("FAIL midclear_reach: addr=%0d busy=%b, required sweep to reach addr=1000",
               s_bram_addr, s_busy);
    end
    rst_n = 1'b0;
    tick();
    total++;
    if ({s_bram_addr, s_bram_din, s_bram_we, s_busy, s_fd, s_rerr, s_cnt} !== '0) begin
      bad++;
      $display("FAIL midclear_reset: addr=%0d din=%h we=%b busy=%b fd=%b rerr=%b cnt=%0d, required all 0",
               s_bram_addr, s_bram_din, s_bram_we, s_busy, s_fd, s_rerr, s_cnt);
    end
    rst_n = 1'b1;
    s_wr_i = 1'b1; s_addr_i = 19'd3; s_color_i = 8'h5A;
    tick();
    total++;
    if ({s_bram_we, s_bram_addr, s_bram_din, s_busy, s_cnt} !== {1'b1, 19'd3, 8'h5A, 1'b0, 16'd0}) begin
      bad++;
      $display("FAIL midclear_after: we=%b addr=%0d din=%h busy=%b cnt=%0d, required we=1 addr=3 din=5a busy=0 cnt=0",
               s_bram_we, s_bram_addr, s_bram_din, s_busy, s_cnt);
    end
    s_wr_i = 1'b0;
  endtask

  task automatic test_saturation();
    apply_reset();
    s_wr_i = 1'b1; s_addr_i = 19'd1; s_req_n_i = 1'b0;
    for (int i = 1; i <= 65700; i++) begin
      tick();
      if (i == 1001) begin
        total++;
        if (s_cnt !== 16'd1000) begin
          bad++;
          $display("FAIL sat_midcount: cnt=%0d, required 1000", s_cnt);
        end
      end
    end
    total++;
    if (s_cnt !== 16'hFFFF) begin
      bad++;
      $display("FAIL sat_reach: cnt=%h, required ffff", s_cnt);
    end
    repeat (5) tick();
    total++;
    if ({s_cnt, s_bram_we, s_busy} !== {16'hFFFF, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL sat_hold: cnt=%h we=%b busy=%b, required cnt=ffff we=0 busy=1",
               s_cnt, s_bram_we, s_busy);
    end
    s_req_n_i = 1'b1; s_wr_i = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    s_wr_i = 1'b0; s_req_n_i = 1'b1; s_addr_i = '0; s_color_i = '0;
    d_wr_i = 1'b0; d_req_n_i = 1'b1; d_addr_i = '0; d_color_i = '0;
    #2;
    test_reset();
    test_pass_through();
    test_bounds();
    test_clear_sweep();
    test_drop_hold();
    test_reset_mid_clear();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fbuf_write_controller.md
Name: fbuf_write_controller

Overview:
Sits directly downstream of the pixel source (test pattern generator or later renderers) and owns the framebuffer BRAM write port. It passes pixel writes through with one register stage, bounds-checks addresses, and runs a full-frame clear sweep whenever the source asserts its clear request (pixel_fbuf_rst_req_n low). It flags end-of-frame writes, and flags and counts writes it drops.

Parameters:
FRAME_WIDTH, 640, output frame width in display pixels
FRAME_HEIGHT, 480, output frame height in display pixels
SCALING_FACTOR, 1, integer downscale; stored frame is (FRAME_WIDTH/SCALING_FACTOR) x (FRAME_HEIGHT/SCALING_FACTOR)
FBUF_ADDR_WIDTH, 19, framebuffer address width
FBUF_DATA_WIDTH, 8, pixel width (RGB332)
CLEAR_COLOR, 0, value written to every location during a clear sweep

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous, active-low reset
pixel_fbuf_address  in  FBUF_ADDR_WIDTH  upstream write address
pixel_fbuf_color  in  FBUF_DATA_WIDTH  upstream write data
pixel_fbuf_wr_en  in  1  upstream write strobe
pixel_fbuf_rst_req_n  in  1  active-low clear request, level-sensitive
bram_addr  out  FBUF_ADDR_WIDTH  BRAM write address (registered)
bram_din  out  FBUF_DATA_WIDTH  BRAM write data (registered)
bram_we  out  1  BRAM write enable (registered)
clear_busy  out  1  high while in CLEAR or HOLD (registered)
frame_done  out  1  one-cycle pulse with the write to the last address in PASS
range_err  out  1  sticky; set by any out-of-range upstream write
dropped_count  out  16  saturating count of upstream writes dropped during CLEAR/HOLD

Behaviour:
- Clocking/reset: one clock, `clk`. Reset is synchronous and active-low on `rst_n`.
- DEPTH = (FRAME_WIDTH/SCALING_FACTOR)*(FRAME_HEIGHT/SCALING_FACTOR).
- Elaboration must fail if DEPTH > 2^FBUF_ADDR_WIDTH.
- Reset (rst_n==0 at a clk edge): state=PASS, clear counter=0, and every output register = 0.
- Reset mid-sweep aborts the clear. Memory contents are undefined afterwards. The next cycle is PASS.
- PASS state:
  - 1-cycle latency: bram_addr<=pixel_fbuf_address and bram_din<=pixel_fbuf_color every cycle.
  - bram_we<=pixel_fbuf_wr_en && (pixel_fbuf_address < DEPTH).
  - wr_en with address >= DEPTH: bram_we=0 and range_err<=1. range_err stays set until rst_n.
  - frame_done<=1 for exactly one cycle, coincident with bram_we=1 at address DEPTH-1. Otherwise 0.
  - pixel_fbuf_rst_req_n==0 sampled in PASS: go to CLEAR and load counter=0.
    - The upstream write in that same cycle is still passed through (pass wins that cycle).
    - clear_busy goes to 1 on the next edge.
- CLEAR state:
  - Each cycle: bram_addr<=counter, bram_din<=CLEAR_COLOR, bram_we<=1, counter++.
  - Exactly DEPTH writes, addresses 0..DEPTH-1 in order, no gaps.
  - frame_done stays 0.
  - After issuing address DEPTH-1: if rst_req_n==0 go to HOLD, else go to PASS.
  - The counter never wraps past DEPTH-1.
- HOLD state: bram_we=0. Go to PASS on the first cycle rst_req_n==1.
- Drops in CLEAR/HOLD:
  - Upstream wr_en is dropped (not written) and dropped_count increments.
  - dropped_count saturates at 16'hFFFF and clears only on rst_n.
  - Address range is not checked for dropped writes.
- clear_busy = 1 in every cycle whose registered outputs come from CLEAR or HOLD.
- Deassertion of rst_req_n mid-sweep does not shorten the sweep.

Test Plan:
- Pass-through: reset, then wr_en=1, addr=5, color=8'hE0 -> next cycle bram_addr=5, bram_din=8'hE0, bram_we=1; range_err=0.
- Bounds: default params, wr_en=1, addr=307200 -> bram_we=0 next cycle, range_err=1 and stays 1. addr=307199 -> bram_we=1 and frame_done pulses for one cycle.
- Clear sweep (SCALING_FACTOR=8, DEPTH=4800): rst_req_n low for 1 cycle -> clear_busy=1 from the next cycle.
  - Required: 4800 consecutive writes, addr 0..4799, din=CLEAR_COLOR, no frame_done.
  - Then PASS with clear_busy=0.
- Drop/hold (DEPTH=4800): hold rst_req_n low for 6000 cycles while wr_en=1 continuously.
  - Required: sweep completes, then HOLD with bram_we=0.
  - Release -> PASS on the next cycle; dropped_count equals the number of wr_en cycles spent in CLEAR+HOLD.
- Reset mid-clear: assert rst_n=0 at sweep address 1000 -> all outputs 0. After release: PASS, a pass-through write to addr 3 appears next cycle, clear_busy=0, dropped_count=0.
- Saturation: force more than 65535 dropped writes in HOLD -> dropped_count holds at 16'hFFFF.
